// File: rtl/zone_irrigation_fsm.sv
// Multi-zone irrigation sequencer: one shared pump, ZONES valves served round-robin,
// with pump priming, a per-zone on-time limit and pressure-loss fault latching.
module zone_irrigation_fsm #(
  parameter int ZONES        = 4,
  parameter int PRIME_TICKS  = 8,
  parameter int MAX_ON_TICKS = 32
) (
  input  logic                       Ck,
  input  logic                       Clr,
  input  logic                       H1,
  input  logic                       O6,
  input  logic                       I_rain,
  input  logic                       I_press,
  input  logic [ZONES-1:0]           I_dry,
  output logic                       pump,
  output logic [ZONES-1:0]           valve,
  output logic                       alarm,
  output logic                       busy,
  output logic [$clog2(ZONES)-1:0]   zone_idx
);

  // state    | meaning
  // S_IDLE   | pump off, waiting for go with at least one dry zone
  // S_PRIME  | pump on, waiting for line pressure
  // S_WATER  | pump on, valve of zone_idx open
  // S_SWITCH | one cycle between zones, advances the round-robin pointer
  // S_FAULT  | latched alarm until the schedule window closes

  localparam int IW   = $clog2(ZONES);
  localparam int TMAX = (PRIME_TICKS > MAX_ON_TICKS) ? PRIME_TICKS : MAX_ON_TICKS;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] PRIME_LAST = CW'(PRIME_TICKS - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(MAX_ON_TICKS - 1);
  localparam logic [IW-1:0] ZONE_LAST  = IW'(ZONES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRIME  = 3'd1,
    S_WATER  = 3'd2,
    S_SWITCH = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     zone_idx_q, zone_idx_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              pump_q, pump_d;
  logic [ZONES-1:0]  valve_q, valve_d;
  logic              alarm_q, alarm_d;
  logic              busy_q, busy_d;

  logic              go;
  logic              any_dry;
  logic [IW-1:0]     rr_next;

  // First dry zone at or after start, wrapping past ZONES-1 to 0.
  function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] start,
                                            input logic [ZONES-1:0] dry);
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;
    int            idx;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < ZONES; k++) begin
      idx = int'(start) + k;
      if (idx >= ZONES) idx = idx - ZONES;
      cand = IW'(idx);
      if (!found && dry[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    zone_idx_d = zone_idx_q;
    rr_ptr_d   = rr_ptr_q;

    go      = H1 & ~O6 & ~I_rain;
    any_dry = |I_dry;
    rr_next = (zone_idx_q == ZONE_LAST) ? '0 : zone_idx_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (go && any_dry) begin
          zone_idx_d = rr_pick(rr_ptr_q, I_dry);
          cnt_d      = '0;
          state_d    = S_PRIME;
        end
      end
      S_PRIME: begin
        if (!go) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (I_press) begin
          state_d = S_WATER;
          cnt_d   = '0;
        end else if (cnt_q == PRIME_LAST) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WATER: begin
        // abort beats pressure loss, pressure loss beats completion
        if (!go) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!I_press) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (!I_dry[zone_idx_q] || (cnt_q == ON_LAST)) begin
          state_d = S_SWITCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SWITCH: begin
        rr_ptr_d = rr_next;
        cnt_d    = '0;
        if (go && any_dry) begin
          zone_idx_d = rr_pick(rr_next, I_dry);
          state_d    = S_PRIME;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (!H1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are the Moore decode of the next state, so they register alongside it.
    pump_d  = (state_d == S_PRIME) || (state_d == S_WATER) || (state_d == S_SWITCH);
    busy_d  = pump_d;
    alarm_d = (state_d == S_FAULT);
    valve_d = '0;
    if (state_d == S_WATER) valve_d[zone_idx_d] = 1'b1;
  end

  always_ff @(posedge Ck) begin
    if (!Clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      zone_idx_q <= '0;
      rr_ptr_q   <= '0;
      pump_q     <= 1'b0;
      valve_q    <= '0;
      alarm_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      zone_idx_q <= zone_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      pump_q     <= pump_d;
      valve_q    <= valve_d;
      alarm_q    <= alarm_d;
      busy_q     <= busy_d;
    end
  end

  assign pump     = pump_q;
  assign valve    = valve_q;
  assign alarm    = alarm_q;
  assign busy     = busy_q;
  assign zone_idx = zone_idx_q;

endmodule

// File: doc/zone_irrigation_fsm.md
# zone_irrigation_fsm

Parametrised multi-zone irrigation controller, successor to the single-channel operation FSM. It sequences one shared pump and up to ZONES solenoid valves. A zone is watered only while the schedule window is open, supply is not inhibited, and it is not raining. Dry zones are served round-robin, with pump priming, a per-zone maximum on-time and pressure-loss fault detection.

## Interface
- ZONES, 4: number of irrigated zones/valves (2..16)
- PRIME_TICKS, 8: max cycles in PRIME waiting for pressure before fault (≥1)
- MAX_ON_TICKS, 32: max cycles a valve stays open per service (≥1)
- Ck  in  1  system clock, all logic on rising edge
- Clr  in  1  synchronous, active-low reset
- H1  in  1  schedule window open (1 = watering permitted)
- O6  in  1  supply inhibit from reservoir FSM (1 = inhibit)
- I_rain  in  1  rain sensor (1 = raining)
- I_press  in  1  line pressure OK
- I_dry  in  ZONES  per-zone soil-dry flags (1 = needs water)
- pump  out  1  pump command
- valve  out  ZONES  valve commands; one-hot or zero
- alarm  out  1  fault indicator
- busy  out  1  high in any state except IDLE/FAULT
- zone_idx  out  $clog2(ZONES)  zone currently or last selected

## Operation
- States: IDLE, PRIME, WATER, SWITCH, FAULT. Outputs are Moore-decoded from the state register.
- Internal terms:
  - go = H1 & ~O6 & ~I_rain
  - abort = ~go
  - rr_ptr = round-robin pointer, ZONES-wide index
- IDLE: pump=0, valve=0, alarm=0. If go & |I_dry: latch zone_idx = first set I_dry bit searching rr_ptr, rr_ptr+1, … with wrap mod ZONES; clear the counter; go to PRIME.
- PRIME: pump=1, valve=0. Priority order:
  - abort → IDLE
  - I_press → WATER, clear counter
  - counter == PRIME_TICKS-1 → FAULT
  - else increment counter
- WATER: pump=1, valve = one-hot(zone_idx). Priority order:
  - abort → IDLE
  - ~I_press → FAULT
  - ~I_dry[zone_idx] or counter == MAX_ON_TICKS-1 → SWITCH
  - else increment counter
- SWITCH (exactly 1 cycle): pump=1, valve=0. rr_ptr ← (zone_idx+1) mod ZONES.
  - If go & |I_dry: reselect from the new rr_ptr, clear counter → PRIME.
  - Else → IDLE.
- FAULT: pump=0, valve=0, alarm=1, busy=0. Stays latched until H1 samples 0 (→ IDLE, alarm clears) or reset.
- The counter is $clog2(max(PRIME_TICKS,MAX_ON_TICKS)+1) bits wide and never wraps: it is cleared on each state entry.
- At most one valve is open at any time. No valve is open with pump=0.
- The rr_ptr search wraps past ZONES-1 to 0. A zone re-dry immediately after its own service is served only after the other dry zones.

## Timing
- Reset (Clr=0 at an edge), next state: IDLE, pump=0, valve=0, alarm=0, busy=0, zone_idx=0, rr_ptr=0, counter=0. Reset dominates every other input, including mid-WATER and FAULT.
- IDLE→PRIME: pump rises on the edge that samples go & |I_dry (1-cycle latency).
- PRIME→WATER: valve opens on the edge that samples I_press=1. Minimum 1 cycle in PRIME.
- WATER lasts at most MAX_ON_TICKS cycles.
- Prime timeout: FAULT is entered after exactly PRIME_TICKS cycles in PRIME with I_press=0.
- Abort in PRIME/WATER: pump and valve are 0 on the next edge. No alarm.
- Simultaneous events: abort beats pressure fault, and pressure fault beats completion. In WATER, I_press falling on the same edge as I_dry clearing → FAULT.
- I_dry changes while in PRIME do not change the latched zone_idx.

## Test plan
Bench uses ZONES=4, PRIME_TICKS=3, MAX_ON_TICKS=5.
- Reset: Clr=0 for 2 edges with H1=1 and I_dry=4'b1111 → pump=0, valve=0, alarm=0, zone_idx=0, state IDLE.
- Normal cycle: H1=1, O6=0, I_rain=0, I_dry=4'b0100; I_press rises 1 cycle after pump; I_dry cleared after 3 WATER cycles → pump=1 for PRIME, then valve=4'b0100 for 3 cycles, then 1 SWITCH cycle, then IDLE with pump=0; zone_idx=2.
- Round-robin/max-on: I_dry=4'b1010 held, I_press=1 → zone 1 valve open exactly 5 cycles, SWITCH, PRIME, zone 3 for 5 cycles, then zone 1 again. valve is never two-hot.
- Prime timeout: I_press held 0 → after 3 PRIME cycles alarm=1, pump=0; alarm holds while H1=1 and clears one edge after H1=0.
- Abort and pressure loss:
  - I_rain=1 in cycle 2 of WATER → next edge pump=0, valve=0, alarm=0.
  - Separate run: I_press drops in WATER → FAULT, alarm=1.
  - Separate run: O6=1 in PRIME → IDLE.
- Reset mid-WATER: Clr=0 during zone 3 service → all outputs 0 next edge. After release with I_dry=4'b1001, zone 0 is served first (rr_ptr=0).
